// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter behind a small byte FIFO. The line idles high, and tx falls two clocks after a byte is accepted into an empty, idle block.
// tx_ready drops while the FIFO is full. A pop does not free a slot for a push in the same cycle.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rdy_en;
  logic          push;
  logic          pop;
  logic          bit_end;

  // rdy_en keeps tx_ready low during reset, even though the count is already zero
  assign tx_ready = rdy_en && (fifo_count != CW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign bit_end  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
